// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit -- control path for a five-stage RV32I-style pipeline.
// Decodes the D-stage instruction fields into control signals, then
// carries them through the E, M and W stages. Branch resolution
// (pcsrc_e) is formed in E from the ALU flags.

module pipe_ctrl_unit #(
   parameter int ALUCTL_W = 4,
   parameter int EN_EXT   = 1
) (
   input  logic                clk,
   input  logic                rst,

   // D-stage instruction fields
   input  logic [6:0]          op,
   input  logic [2:0]          funct3,
   input  logic                funct7b5,

   // E-stage control and ALU flags
   input  logic                flush_e,
   input  logic                zero_e,
   input  logic                lt_e,
   input  logic                ltu_e,

   // D-stage combinational outputs
   output logic [2:0]          immsrc_d,
   output logic                illegal_d,

   // E-stage outputs
   output logic                regwrite_e,
   output logic [1:0]          resultsrc_e,
   output logic                memwrite_e,
   output logic                alusrc_e,
   output logic                alusrca_e,
   output logic [ALUCTL_W-1:0] alucontrol_e,
   output logic                jump_e,
   output logic                jalr_e,
   output logic                pcsrc_e,

   // M-stage outputs
   output logic                regwrite_m,
   output logic [1:0]          resultsrc_m,
   output logic                memwrite_m,

   // W-stage outputs
   output logic                regwrite_w,
   output logic [1:0]          resultsrc_w
);

   // Extensions (jalr, lui, auipc, non-beq branches) are either all
   // decoded or all rejected as illegal.
   localparam bit EXT_ON = (EN_EXT != 0);

   // Opcodes
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   // Immediate formats
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // ALU control codes
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLL  = 4'b0110;
   localparam logic [3:0] ALU_SRL  = 4'b0111;
   localparam logic [3:0] ALU_SRA  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   // Result source select
   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;
   localparam logic [1:0] RES_IMM = 2'b11;

   // R-type and I-ALU share one funct3 table. Only R-type uses
   // funct7b5 to pick sub, because for addi bit 30 is part of the
   // immediate. For the shifts, both formats use it to pick sra.
   function automatic logic [3:0] alu_map(input logic [2:0] f3,
                                          input logic       f7,
                                          input logic       is_r);
      logic [3:0] code;
      case (f3)
         3'b000:  code = (is_r && f7) ? ALU_SUB : ALU_ADD;
         3'b001:  code = ALU_SLL;
         3'b010:  code = ALU_SLT;
         3'b011:  code = ALU_SLTU;
         3'b100:  code = ALU_XOR;
         3'b101:  code = f7 ? ALU_SRA : ALU_SRL;
         3'b110:  code = ALU_OR;
         default: code = ALU_AND;
      endcase
      return code;
   endfunction

   // Decoded D-stage controls
   logic       regwrite_d;
   logic [1:0] resultsrc_d;
   logic       memwrite_d;
   logic       alusrc_d;
   logic       alusrca_d;
   logic [3:0] alu_d;
   logic       jump_d;
   logic       jalr_d;
   logic       branch_d;

   // E-stage state that is not a port
   logic       branch_e;
   logic [2:0] br_f3_e;
   logic       br_cond;

   // Main decoder. Everything defaults to a bubble, and only legal
   // encodings turn enables on, so an illegal instruction needs no
   // separate clean-up path.
   always_comb begin
      regwrite_d  = 1'b0;
      resultsrc_d = RES_ALU;
      memwrite_d  = 1'b0;
      alusrc_d    = 1'b0;
      alusrca_d   = 1'b0;
      alu_d       = ALU_ADD;
      jump_d      = 1'b0;
      jalr_d      = 1'b0;
      branch_d    = 1'b0;
      immsrc_d    = IMM_I;
      illegal_d   = 1'b0;

      case (op)
         OP_LW: begin
            regwrite_d  = 1'b1;
            alusrc_d    = 1'b1;
            resultsrc_d = RES_MEM;
         end
         OP_SW: begin
            memwrite_d = 1'b1;
            alusrc_d   = 1'b1;
            immsrc_d   = IMM_S;
         end
         OP_R: begin
            regwrite_d = 1'b1;
            alu_d      = alu_map(funct3, funct7b5, 1'b1);
         end
         OP_I: begin
            regwrite_d = 1'b1;
            alusrc_d   = 1'b1;
            alu_d      = alu_map(funct3, funct7b5, 1'b0);
         end
         OP_B: begin
            if (funct3 == 3'b010 || funct3 == 3'b011 ||
                (!EXT_ON && funct3 != 3'b000)) begin
               illegal_d = 1'b1;
            end else begin
               branch_d = 1'b1;
               immsrc_d = IMM_B;
               alu_d    = ALU_SUB;
            end
         end
         OP_JAL: begin
            regwrite_d  = 1'b1;
            jump_d      = 1'b1;
            immsrc_d    = IMM_J;
            resultsrc_d = RES_PC4;
         end
         OP_JALR: begin
            if (EXT_ON && funct3 == 3'b000) begin
               regwrite_d  = 1'b1;
               jump_d      = 1'b1;
               jalr_d      = 1'b1;
               alusrc_d    = 1'b1;
               resultsrc_d = RES_PC4;
            end else begin
               illegal_d = 1'b1;
            end
         end
         OP_LUI: begin
            if (EXT_ON) begin
               regwrite_d  = 1'b1;
               immsrc_d    = IMM_U;
               resultsrc_d = RES_IMM;
            end else begin
               illegal_d = 1'b1;
            end
         end
         OP_AUIPC: begin
            if (EXT_ON) begin
               regwrite_d = 1'b1;
               immsrc_d   = IMM_U;
               alusrc_d   = 1'b1;
               alusrca_d  = 1'b1;
            end else begin
               illegal_d = 1'b1;
            end
         end
         default: illegal_d = 1'b1;
      endcase
   end

   // D-to-E register. Reset beats flush, and flush beats the decode.
   // Both load a bubble.
   always_ff @(posedge clk) begin
      if (rst || flush_e) begin
         regwrite_e   <= 1'b0;
         resultsrc_e  <= RES_ALU;
         memwrite_e   <= 1'b0;
         alusrc_e     <= 1'b0;
         alusrca_e    <= 1'b0;
         alucontrol_e <= '0;
         jump_e       <= 1'b0;
         jalr_e       <= 1'b0;
         branch_e     <= 1'b0;
         br_f3_e      <= 3'b000;
      end else begin
         regwrite_e   <= regwrite_d;
         resultsrc_e  <= resultsrc_d;
         memwrite_e   <= memwrite_d;
         alusrc_e     <= alusrc_d;
         alusrca_e    <= alusrca_d;
         alucontrol_e <= ALUCTL_W'(alu_d);
         jump_e       <= jump_d;
         jalr_e       <= jalr_d;
         branch_e     <= branch_d;
         br_f3_e      <= funct3;
      end
   end

   // Branch condition, chosen by the funct3 captured with the branch.
   // The codes 010 and 011 never get here as a live branch, so they
   // resolve to not-taken.
   always_comb begin
      br_cond = 1'b0;
      case (br_f3_e)
         3'b000:  br_cond = zero_e;
         3'b001:  br_cond = !zero_e;
         3'b100:  br_cond = lt_e;
         3'b101:  br_cond = !lt_e;
         3'b110:  br_cond = ltu_e;
         3'b111:  br_cond = !ltu_e;
         default: br_cond = 1'b0;
      endcase
   end

   assign pcsrc_e = jump_e | (branch_e & br_cond);

   // E-to-M register. It never stalls, and reset drops the
   // instruction that is in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         regwrite_m  <= 1'b0;
         resultsrc_m <= RES_ALU;
         memwrite_m  <= 1'b0;
      end else begin
         regwrite_m  <= regwrite_e;
         resultsrc_m <= resultsrc_e;
         memwrite_m  <= memwrite_e;
      end
   end

   // M-to-W register. It never stalls, and reset drops the
   // instruction that is in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         regwrite_w  <= 1'b0;
         resultsrc_w <= RES_ALU;
      end else begin
         regwrite_w  <= regwrite_m;
         resultsrc_w <= resultsrc_m;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed testbench for pipe_ctrl_unit. The main instance has the
// extensions enabled. A second instance built with EN_EXT=0 shares
// the same inputs.

module tb_pipe_ctrl_unit;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_BAD   = 7'b1111111;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       flush_e;
   logic       zero_e;
   logic       lt_e;
   logic       ltu_e;

   logic [2:0] immsrc_d;
   logic       illegal_d;
   logic       regwrite_e, memwrite_e, alusrc_e, alusrca_e;
   logic       jump_e, jalr_e, pcsrc_e;
   logic [1:0] resultsrc_e;
   logic [3:0] alucontrol_e;
   logic       regwrite_m, memwrite_m, regwrite_w;
   logic [1:0] resultsrc_m, resultsrc_w;

   logic [2:0] immsrc_d2;
   logic       illegal_d2;
   logic       regwrite_e2, memwrite_e2, alusrc_e2, alusrca_e2;
   logic       jump_e2, jalr_e2, pcsrc_e2;
   logic [1:0] resultsrc_e2;
   logic [3:0] alucontrol_e2;
   logic       regwrite_m2, memwrite_m2, regwrite_w2;
   logic [1:0] resultsrc_m2, resultsrc_w2;

   int total = 0;
   int bad   = 0;

   pipe_ctrl_unit #(.ALUCTL_W(4), .EN_EXT(1)) dut (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .flush_e(flush_e), .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
      .immsrc_d(immsrc_d), .illegal_d(illegal_d),
      .regwrite_e(regwrite_e), .resultsrc_e(resultsrc_e), .memwrite_e(memwrite_e),
      .alusrc_e(alusrc_e), .alusrca_e(alusrca_e), .alucontrol_e(alucontrol_e),
      .jump_e(jump_e), .jalr_e(jalr_e), .pcsrc_e(pcsrc_e),
      .regwrite_m(regwrite_m), .resultsrc_m(resultsrc_m), .memwrite_m(memwrite_m),
      .regwrite_w(regwrite_w), .resultsrc_w(resultsrc_w)
   );

   pipe_ctrl_unit #(.ALUCTL_W(4), .EN_EXT(0)) dut_noext (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .flush_e(flush_e), .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
      .immsrc_d(immsrc_d2), .illegal_d(illegal_d2),
      .regwrite_e(regwrite_e2), .resultsrc_e(resultsrc_e2), .memwrite_e(memwrite_e2),
      .alusrc_e(alusrc_e2), .alusrca_e(alusrca_e2), .alucontrol_e(alucontrol_e2),
      .jump_e(jump_e2), .jalr_e(jalr_e2), .pcsrc_e(pcsrc_e2),
      .regwrite_m(regwrite_m2), .resultsrc_m(resultsrc_m2), .memwrite_m(memwrite_m2),
      .regwrite_w(regwrite_w2), .resultsrc_w(resultsrc_w2)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Drive the D-stage instruction fields and the flush request.
   task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3,
                                input logic f7, input logic fl);
      op       = o;
      funct3   = f3;
      funct7b5 = f7;
      flush_e  = fl;
      #1;
   endtask

   // Compare one observed value against the expected value.
   task automatic checkOutput(input string tag, input logic [7:0] obs,
                              input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Linear sequence of directed steps
   initial begin
      rst = 1'b1; zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0;
      applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("rst_regwrite_e",  regwrite_e,  0);
      checkOutput("rst_resultsrc_e", resultsrc_e, 0);
      checkOutput("rst_memwrite_e",  memwrite_e,  0);
      checkOutput("rst_alucontrol_e", alucontrol_e, 0);
      checkOutput("rst_jump_e",      jump_e,      0);
      checkOutput("rst_pcsrc_e",     pcsrc_e,     0);
      checkOutput("rst_regwrite_m",  regwrite_m,  0);
      checkOutput("rst_memwrite_m",  memwrite_m,  0);
      checkOutput("rst_regwrite_w",  regwrite_w,  0);
      checkOutput("rst_resultsrc_w", resultsrc_w, 0);
      checkOutput("lw_illegal_d_in_rst", illegal_d, 0);

      // lw
      rst = 1'b0;
      applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0);
      checkOutput("lw_immsrc_d", immsrc_d, 3'b000);
      tick();
      checkOutput("lw_regwrite_e",  regwrite_e,  1);
      checkOutput("lw_resultsrc_e", resultsrc_e, 2'b01);
      checkOutput("lw_alusrc_e",    alusrc_e,    1);
      checkOutput("lw_alucontrol_e", alucontrol_e, 4'b0000);
      checkOutput("lw_pcsrc_e",     pcsrc_e,     0);

      // sub
      applyStimulus(OP_R, 3'b000, 1'b1, 1'b0);
      tick();
      checkOutput("sub_alucontrol_e", alucontrol_e, 4'b0001);
      checkOutput("sub_alusrc_e",     alusrc_e,     0);
      checkOutput("lw_regwrite_m",    regwrite_m,   1);
      checkOutput("lw_resultsrc_m",   resultsrc_m,  2'b01);

      // addi with bit 30 set still adds
      applyStimulus(OP_I, 3'b000, 1'b1, 1'b0);
      tick();
      checkOutput("addi_alucontrol_e", alucontrol_e, 4'b0000);
      checkOutput("addi_alusrc_e",     alusrc_e,     1);
      checkOutput("lw_regwrite_w",     regwrite_w,   1);
      checkOutput("lw_resultsrc_w",    resultsrc_w,  2'b01);

      // srai
      applyStimulus(OP_I, 3'b101, 1'b1, 1'b0);
      tick();
      checkOutput("srai_alucontrol_e", alucontrol_e, 4'b1000);
      checkOutput("sub_resultsrc_w",   resultsrc_w,  2'b00);

      // bne
      applyStimulus(OP_B, 3'b001, 1'b0, 1'b0);
      checkOutput("bne_immsrc_d",  immsrc_d,  3'b010);
      checkOutput("bne_illegal_d", illegal_d, 0);
      tick();
      zero_e = 1'b0; #1;
      checkOutput("bne_taken_pcsrc_e", pcsrc_e, 1);
      checkOutput("bne_alucontrol_e",  alucontrol_e, 4'b0001);
      checkOutput("bne_regwrite_e",    regwrite_e, 0);
      zero_e = 1'b1; #1;
      checkOutput("bne_nottaken_pcsrc_e", pcsrc_e, 0);

      // bgeu
      zero_e = 1'b0;
      applyStimulus(OP_B, 3'b111, 1'b0, 1'b0);
      tick();
      ltu_e = 1'b0; #1;
      checkOutput("bgeu_taken_pcsrc_e", pcsrc_e, 1);
      ltu_e = 1'b1; #1;
      checkOutput("bgeu_nottaken_pcsrc_e", pcsrc_e, 0);
      ltu_e = 1'b0;

      // branch funct3 010 is illegal
      applyStimulus(OP_B, 3'b010, 1'b0, 1'b0);
      checkOutput("b010_illegal_d", illegal_d, 1);
      checkOutput("b010_immsrc_d",  immsrc_d,  3'b000);
      tick();
      checkOutput("b010_pcsrc_e", pcsrc_e, 0);

      // jalr on both instances
      applyStimulus(OP_JALR, 3'b000, 1'b0, 1'b0);
      checkOutput("jalr_illegal_d",       illegal_d,  0);
      checkOutput("jalr_noext_illegal_d", illegal_d2, 1);
      tick();
      checkOutput("jalr_jump_e",      jump_e,      1);
      checkOutput("jalr_jalr_e",      jalr_e,      1);
      checkOutput("jalr_resultsrc_e", resultsrc_e, 2'b10);
      checkOutput("jalr_pcsrc_e",     pcsrc_e,     1);
      checkOutput("jalr_alusrc_e",    alusrc_e,    1);
      checkOutput("jalr_noext_regwrite_e", regwrite_e2, 0);
      checkOutput("jalr_noext_jump_e",     jump_e2,     0);
      checkOutput("jalr_noext_pcsrc_e",    pcsrc_e2,    0);

      // lui
      applyStimulus(OP_LUI, 3'b000, 1'b0, 1'b0);
      checkOutput("lui_immsrc_d", immsrc_d, 3'b100);
      tick();
      checkOutput("lui_resultsrc_e", resultsrc_e, 2'b11);
      checkOutput("lui_regwrite_e",  regwrite_e,  1);

      // auipc
      applyStimulus(OP_AUIPC, 3'b000, 1'b0, 1'b0);
      tick();
      checkOutput("auipc_alusrca_e", alusrca_e, 1);
      checkOutput("auipc_alusrc_e",  alusrc_e,  1);
      checkOutput("lui_regwrite_m",  regwrite_m, 1);

      // sw with flush
      applyStimulus(OP_SW, 3'b010, 1'b0, 1'b1);
      checkOutput("sw_immsrc_d", immsrc_d, 3'b001);
      tick();
      checkOutput("swflush_memwrite_e", memwrite_e, 0);
      applyStimulus(OP_R, 3'b000, 1'b0, 1'b0);
      tick();
      checkOutput("swflush_memwrite_m", memwrite_m, 0);

      // sw without flush, then reset while it is in M
      applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0);
      tick();
      checkOutput("sw_memwrite_e", memwrite_e, 1);
      applyStimulus(OP_I, 3'b000, 1'b0, 1'b0);
      tick();
      checkOutput("sw_memwrite_m", memwrite_m, 1);
      rst = 1'b1;
      applyStimulus(OP_BAD, 3'b000, 1'b0, 1'b0);
      checkOutput("bad_illegal_d_in_rst", illegal_d, 1);
      tick();
      checkOutput("rstmid_memwrite_m", memwrite_m, 0);
      checkOutput("rstmid_regwrite_m", regwrite_m, 0);
      checkOutput("rstmid_regwrite_e", regwrite_e, 0);
      applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0);
      tick();
      checkOutput("rstmid_regwrite_w", regwrite_w, 0);
      checkOutput("rstmid_lw_regwrite_e", regwrite_e, 0);

      // jal after reset
      rst = 1'b0;
      applyStimulus(OP_JAL, 3'b000, 1'b0, 1'b0);
      checkOutput("jal_immsrc_d", immsrc_d, 3'b011);
      tick();
      checkOutput("jal_pcsrc_e",     pcsrc_e,     1);
      checkOutput("jal_jalr_e",      jalr_e,      0);
      checkOutput("jal_resultsrc_e", resultsrc_e, 2'b10);

      // unlisted opcode becomes a bubble
      applyStimulus(OP_BAD, 3'b000, 1'b0, 1'b0);
      checkOutput("bad_illegal_d", illegal_d, 1);
      tick();
      checkOutput("bad_regwrite_e", regwrite_e, 0);
      checkOutput("bad_pcsrc_e",    pcsrc_e,    0);
      checkOutput("jal_regwrite_m", regwrite_m, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 The block SHALL have parameter ALUCTL_W, default 4, ALU control width; legal values >= 4; upper bits beyond 4 SHALL be zero.
REQ-002 The block SHALL have parameter EN_EXT, default 1; 1 enables jalr/lui/auipc/bne/blt/bge/bltu/bgeu decode, 0 treats them as illegal.
REQ-003 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have port op, input, 7, D-stage opcode.
REQ-006 The block SHALL have port funct3, input, 3, D-stage funct3.
REQ-007 The block SHALL have port funct7b5, input, 1, D-stage instr[30].
REQ-008 The block SHALL have port flush_e, input, 1, which inserts a bubble into the E stage.
REQ-009 The block SHALL have port zero_e, input, 1, ALU result equal zero.
REQ-010 The block SHALL have port lt_e, input, 1, signed less-than.
REQ-011 The block SHALL have port ltu_e, input, 1, unsigned less-than.
REQ-012 The block SHALL have port immsrc_d, output, 3, combinational immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-013 The block SHALL have port illegal_d, output, 1, combinational unsupported opcode or funct.
REQ-014 The block SHALL have E-stage outputs regwrite_e 1, resultsrc_e 2, memwrite_e 1, alusrc_e 1, alusrca_e 1 (1 = PC operand), alucontrol_e ALUCTL_W, jump_e 1, jalr_e 1, and pcsrc_e 1 (combinational).
REQ-015 The block SHALL have M-stage outputs regwrite_m, resultsrc_m[1:0], memwrite_m.
REQ-016 The block SHALL have W-stage outputs regwrite_w, resultsrc_w[1:0].

Function
REQ-017 Decode SHALL be: lw 0000011 (regwrite=1, immsrc=I, alusrc=1, resultsrc=01, add); sw 0100011 (memwrite=1, immsrc=S, alusrc=1, add); R 0110011 (regwrite=1, resultsrc=00); I-ALU 0010011 (regwrite=1, alusrc=1, immsrc=I); B 1100011 (branch=1, immsrc=B, sub); jal 1101111 (regwrite=1, jump=1, immsrc=J, resultsrc=10); jalr 1100111 (as jal plus immsrc=I, alusrc=1, jalr=1, add); lui 0110111 (regwrite=1, immsrc=U, resultsrc=11); auipc 0010111 (regwrite=1, immsrc=U, alusrc=1, alusrca=1, add).
REQ-018 ALU control codes SHALL be: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sll 0110, srl 0111, sra 1000, sltu 1001.
REQ-019 R/I-ALU funct3 mapping SHALL be: 000 add, or sub when R and funct7b5=1; 001 sll; 010 slt; 011 sltu; 100 xor; 101 srl, or sra when funct7b5=1; 110 or; 111 and.
REQ-020 Illegal inputs (unlisted opcode, branch funct3 010/011, jalr funct3 not 000, or EN_EXT=0 extensions) SHALL raise illegal_d and decode as a bubble with all enables 0, immsrc 000, and add.
REQ-021 On each rising edge, the D-to-E register SHALL load the decoded controls and branch funct3 (br_f3_e, internal).
REQ-022 E-to-M and M-to-W registers SHALL advance every cycle with no stall input.
REQ-023 flush_e=1 SHALL load a bubble into E (all enables 0, resultsrc 00, alucontrol 0), overriding decode in the same cycle.
REQ-024 pcsrc_e SHALL equal jump_e OR (branch_e AND cond), where cond is: 000 zero_e; 001 !zero_e; 100 lt_e; 101 !lt_e; 110 ltu_e; 111 !ltu_e.
REQ-025 Latency SHALL be: D to E one cycle, E to M one cycle, M to W one cycle; memwrite and regwrite SHALL never appear in a stage without the originating instruction.

Reset
REQ-026 While rst=1 at a clock edge, all E/M/W registers SHALL clear to 0 (bubble), and pcsrc_e SHALL be 0 on the following cycle.
REQ-027 Reset SHALL take priority over flush_e and decode; combinational D outputs SHALL be unaffected by rst.
REQ-028 A reset asserted mid-flight SHALL discard every in-flight instruction; no regwrite_w or memwrite_m SHALL assert from pre-reset instructions.

Verification
REQ-029 Bench: rst for 2 cycles -> all registered outputs 0; after release, lw (op=0000011) -> regwrite_e=1, resultsrc_e=01, then regwrite_w=1 and resultsrc_w=01 two cycles later.
REQ-030 Bench: R sub (funct3=000, funct7b5=1) -> alucontrol_e=0001; I-ALU with funct7b5=1 and funct3=000 -> 0000; funct3=101 with funct7b5=1 -> 1000.
REQ-031 Bench: bne in E with zero_e=0 -> pcsrc_e=1; zero_e=1 -> 0; bgeu with ltu_e=0 -> 1.
REQ-032 Bench: sw decoded with flush_e=1 -> memwrite_e=0 and memwrite_m=0 in subsequent cycles.
REQ-033 Bench: jalr -> jump_e=1, jalr_e=1, resultsrc_e=10, pcsrc_e=1; with EN_EXT=0 -> illegal_d=1 and E bubble.
REQ-034 Bench: op=1111111 -> illegal_d=1; rst asserted while sw is in M -> memwrite_m=0 the next cycle.
